// File: rtl/encoder_16_4_serial.sv
// Serial 16-to-4 priority encoder: captures a request vector and drains it lowest index first.
// Optional macro ENCODER_16_4_TRISTATE_EN makes handshake outputs float while Enable_In is low.
module encoder_16_4_serial (
  input  logic        Clk_In,
  input  logic        Reset_In,
  input  logic        Enable_In,
  input  logic        Load_In,
  input  logic [15:0] Data_In,
  input  logic        Ready_In,
  output logic [3:0]  Encoded_Value_Out,
  output logic        Valid_Out,
  output logic        Busy_Out,
  output logic        Done_Out,
  output logic [4:0]  Count_Out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pending_q, pending_d;
  logic [4:0]  count_q, count_d;

  logic [3:0]  enc_int;
  logic        valid_int;
  logic        busy_int;
  logic        done_int;

  // Later iterations overwrite earlier ones, so the lowest set bit wins.
  function automatic logic [3:0] lowest_idx(input logic [15:0] v);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  function automatic logic [4:0] popcount(input logic [15:0] v);
    logic [4:0] c;
    c = 5'd0;
    for (int i = 0; i < 16; i++) begin
      c = c + {4'd0, v[i]};
    end
    return c;
  endfunction

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    count_d   = count_q;
    if (Enable_In) begin
      case (state_q)
        IDLE: begin
          if (Load_In) begin
            pending_d = Data_In;
            count_d   = popcount(Data_In);
            state_d   = (Data_In != 16'd0) ? SCAN : DONE;
          end
        end
        SCAN: begin
          if (Ready_In) begin
            // v & (v-1) clears exactly the lowest set bit, i.e. the index just accepted.
            pending_d = pending_q & (pending_q - 16'd1);
            if (pending_d == 16'd0) state_d = DONE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk_In) begin
    if (Reset_In) begin
      state_q   <= IDLE;
      pending_q <= 16'd0;
      count_q   <= 5'd0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      count_q   <= count_d;
    end
  end

  assign enc_int   = (state_q == SCAN) ? lowest_idx(pending_q) : 4'd0;
  assign busy_int  = (state_q == SCAN);
  assign valid_int = (state_q == SCAN) && Enable_In;
  assign done_int  = (state_q == DONE) && Enable_In;

  assign Count_Out = count_q;

`ifdef ENCODER_16_4_TRISTATE_EN
  assign Encoded_Value_Out = Enable_In ? enc_int   : 4'bzzzz;
  assign Valid_Out         = Enable_In ? valid_int : 1'bz;
  assign Busy_Out          = Enable_In ? busy_int  : 1'bz;
  assign Done_Out          = Enable_In ? done_int  : 1'bz;
`else
  assign Encoded_Value_Out = enc_int;
  assign Valid_Out         = valid_int;
  assign Busy_Out          = busy_int;
  assign Done_Out          = done_int;
`endif

endmodule

// File: tb/tb_encoder_16_4_serial.sv
// Directed bench for encoder_16_4_serial (default build, tristate macro undefined).
module tb_encoder_16_4_serial;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        load;
  logic [15:0] data;
  logic        ready;
  logic [3:0]  enc;
  logic        valid;
  logic        busy;
  logic        done;
  logic [4:0]  count;

  int checks   = 0;
  int failures = 0;

  encoder_16_4_serial dut (
    .Clk_In            (clk),
    .Reset_In          (rst),
    .Enable_In         (en),
    .Load_In           (load),
    .Data_In           (data),
    .Ready_In          (ready),
    .Encoded_Value_Out (enc),
    .Valid_Out         (valid),
    .Busy_Out          (busy),
    .Done_Out          (done),
    .Count_Out         (count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Packed as {enc, valid, busy, done, count} so a whole output snapshot is one comparison.
  task automatic chk_all(input string tag, input logic [3:0] e_enc, input logic e_v,
                         input logic e_b, input logic e_d, input logic [4:0] e_c);
    chk(tag, {4'd0, enc, valid, busy, done, count}, {4'd0, e_enc, e_v, e_b, e_d, e_c});
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; load = 1'b0; data = 16'd0; ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk_all("reset_state", 4'd0, 1'b0, 1'b0, 1'b0, 5'd0);

    // 16'h8421: indices 0,5,10,15 back to back, then one Done cycle
    data = 16'h8421; load = 1'b1; ready = 1'b1;
    tick(); load = 1'b0;
    chk_all("h8421_idx0", 4'd0, 1'b1, 1'b1, 1'b0, 5'd4);
    tick(); chk_all("h8421_idx5", 4'd5, 1'b1, 1'b1, 1'b0, 5'd4);
    tick(); chk_all("h8421_idx10", 4'd10, 1'b1, 1'b1, 1'b0, 5'd4);
    tick(); chk_all("h8421_idx15", 4'd15, 1'b1, 1'b1, 1'b0, 5'd4);
    tick(); chk_all("h8421_done", 4'd0, 1'b0, 1'b0, 1'b1, 5'd4);
    tick(); chk_all("h8421_idle", 4'd0, 1'b0, 1'b0, 1'b0, 5'd4);

    // zero vector goes straight to Done
    data = 16'h0000; load = 1'b1;
    tick(); load = 1'b0;
    chk_all("zero_done", 4'd0, 1'b0, 1'b0, 1'b1, 5'd0);
    tick(); chk_all("zero_idle", 4'd0, 1'b0, 1'b0, 1'b0, 5'd0);

    // backpressure holds index 1 for three cycles
    data = 16'h0006; load = 1'b1; ready = 1'b0;
    tick(); load = 1'b0;
    chk_all("stall_c1", 4'd1, 1'b1, 1'b1, 1'b0, 5'd2);
    tick(); chk_all("stall_c2", 4'd1, 1'b1, 1'b1, 1'b0, 5'd2);
    tick(); chk_all("stall_c3", 4'd1, 1'b1, 1'b1, 1'b0, 5'd2);
    ready = 1'b1;
    tick(); chk_all("stall_idx2", 4'd2, 1'b1, 1'b1, 1'b0, 5'd2);
    tick(); chk_all("stall_done", 4'd0, 1'b0, 1'b0, 1'b1, 5'd2);
    tick(); chk_all("stall_idle", 4'd0, 1'b0, 1'b0, 1'b0, 5'd2);

    // load during drain is ignored
    data = 16'h0003; load = 1'b1;
    tick();
    chk_all("ovl_idx0", 4'd0, 1'b1, 1'b1, 1'b0, 5'd2);
    data = 16'h00F0;
    tick(); chk_all("ovl_idx1", 4'd1, 1'b1, 1'b1, 1'b0, 5'd2);
    load = 1'b0;
    tick(); chk_all("ovl_done", 4'd0, 1'b0, 1'b0, 1'b1, 5'd2);
    tick(); chk_all("ovl_idle", 4'd0, 1'b0, 1'b0, 1'b0, 5'd2);

    // full vector: 0..15 then Done, count 16
    data = 16'hFFFF; load = 1'b1;
    tick(); load = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk_all($sformatf("ffff_idx%0d", i), 4'(i), 1'b1, 1'b1, 1'b0, 5'd16);
      tick();
    end
    chk_all("ffff_done", 4'd0, 1'b0, 1'b0, 1'b1, 5'd16);
    tick(); chk_all("ffff_idle", 4'd0, 1'b0, 1'b0, 1'b0, 5'd16);

    // reset in mid-drain after the second index
    load = 1'b1;
    tick(); load = 1'b0;
    chk_all("rst_idx0", 4'd0, 1'b1, 1'b1, 1'b0, 5'd16);
    tick(); chk_all("rst_idx1", 4'd1, 1'b1, 1'b1, 1'b0, 5'd16);
    rst = 1'b1;
    tick(); rst = 1'b0;
    chk_all("rst_idle", 4'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    tick(); chk_all("rst_no_done", 4'd0, 1'b0, 1'b0, 1'b0, 5'd0);

    // enable dropped for two cycles mid-drain of 16'h0300
    data = 16'h0300; load = 1'b1;
    tick(); load = 1'b0;
    chk_all("en_idx8", 4'd8, 1'b1, 1'b1, 1'b0, 5'd2);
    en = 1'b0; #1;
    chk_all("en_off0", 4'd8, 1'b0, 1'b1, 1'b0, 5'd2);
    tick(); chk_all("en_off1", 4'd8, 1'b0, 1'b1, 1'b0, 5'd2);
    tick(); chk_all("en_off2", 4'd8, 1'b0, 1'b1, 1'b0, 5'd2);
    en = 1'b1; #1;
    chk_all("en_resume8", 4'd8, 1'b1, 1'b1, 1'b0, 5'd2);
    tick(); chk_all("en_idx9", 4'd9, 1'b1, 1'b1, 1'b0, 5'd2);
    tick(); chk_all("en_done", 4'd0, 1'b0, 1'b0, 1'b1, 5'd2);
    tick(); chk_all("en_idle", 4'd0, 1'b0, 1'b0, 1'b0, 5'd2);

    // Done pulse deferred by disable; load ignored while disabled
    data = 16'h0000; load = 1'b1;
    tick(); load = 1'b0;
    chk_all("dd_done", 4'd0, 1'b0, 1'b0, 1'b1, 5'd0);
    en = 1'b0;
    tick(); chk_all("dd_held", 4'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    en = 1'b1; #1;
    chk_all("dd_emit", 4'd0, 1'b0, 1'b0, 1'b1, 5'd0);
    tick(); chk_all("dd_idle", 4'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    en = 1'b0; data = 16'h0010; load = 1'b1;
    tick(); load = 1'b0; en = 1'b1; #1;
    chk_all("dis_load_ignored", 4'd0, 1'b0, 1'b0, 1'b0, 5'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
